actor_scheduler: RTL

- Parametrised successor to the two-actor selector.
- Frame-synchronous scheduler for N_ACTORS game actors (pacman, ghosts, fruit):
  - on each start pulse, snapshots every actor's position/sprite/enable;
  - streams enabled actors one at a time to the sprite renderer over a valid/ready handshake.
- Optional rotating start priority spreads overdraw/flicker fairly across frames.
- Sits between the game-logic actor registers and the sprite drawing engine.

---
 rtl/actor_scheduler.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/actor_scheduler.sv
// actor_scheduler
//   Frame-synchronous scheduler for N_ACTORS game actors. A start pulse
//   snapshots every actor's position, sprite and enable flag. Enabled actors
//   are then streamed one at a time to the sprite renderer over a valid/ready
//   handshake. All N_ACTORS slots are visited once per frame, in ascending
//   wrapped order beginning at the base index. With ROTATE=1 the base index
//   advances after every completed frame, so overdraw/flicker is shared
//   fairly between actors.
//
// Ports
//   clk           system clock
//   reset         asynchronous, active-high reset
//   start         one-cycle frame-start pulse, accepted only when idle
//   positions     flat bus, actor i at [i*POS_W +: POS_W]
//   sprites       flat bus, actor i at [i*SPR_W +: SPR_W]
//   enables       per-actor visible flag
//   out_valid     position_out/sprite_out/actor_id hold a valid actor
//   out_ready     renderer accepts the current actor
//   position_out  selected actor position
//   sprite_out    selected actor sprite
//   actor_id      index of the selected actor
//   busy          high while scanning or presenting an actor
//   done          one-cycle pulse when the frame list is exhausted
module actor_scheduler #(
  parameter int N_ACTORS = 8,
  parameter int POS_W    = 12,
  parameter int SPR_W    = 8,
  parameter int ID_W     = 4,
  parameter int ROTATE   = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [N_ACTORS*POS_W-1:0] positions,
  input  logic [N_ACTORS*SPR_W-1:0] sprites,
  input  logic [N_ACTORS-1:0]       enables,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [POS_W-1:0]          position_out,
  output logic [SPR_W-1:0]          sprite_out,
  output logic [ID_W-1:0]           actor_id,
  output logic                      busy,
  output logic                      done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_OUT  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [ID_W-1:0] LAST_IDX = ID_W'(N_ACTORS - 1);

  // Wrapping advance of an actor index: N_ACTORS-1 -> 0.
  function automatic logic [ID_W-1:0] next_idx(input logic [ID_W-1:0] i);
    logic [ID_W-1:0] r;
    if (i == LAST_IDX) begin
      r = ID_W'(0);
    end else begin
      r = i + ID_W'(1);
    end
    return r;
  endfunction

  state_t            state_r;
  logic [POS_W-1:0]  snap_pos_r [N_ACTORS];
  logic [SPR_W-1:0]  snap_spr_r [N_ACTORS];
  logic [N_ACTORS-1:0] snap_en_r;
  logic [ID_W-1:0]   idx_r;
  logic [ID_W-1:0]   cnt_r;
  logic [ID_W-1:0]   base_r;

  logic [POS_W-1:0]  sel_pos_s;
  logic [SPR_W-1:0]  sel_spr_s;
  logic              sel_en_s;
  logic              last_s;
  logic [ID_W-1:0]   idx_nxt_s;

  // AND-OR mux of the snapshot entry addressed by idx_r.
  always_comb begin
    sel_pos_s = {POS_W{1'b0}};
    sel_spr_s = {SPR_W{1'b0}};
    sel_en_s  = 1'b0;
    for (int i = 0; i < N_ACTORS; i++) begin
      sel_pos_s = sel_pos_s | ({POS_W{idx_r == ID_W'(i)}} & snap_pos_r[i]);
      sel_spr_s = sel_spr_s | ({SPR_W{idx_r == ID_W'(i)}} & snap_spr_r[i]);
      sel_en_s  = sel_en_s  | ((idx_r == ID_W'(i)) & snap_en_r[i]);
    end
    last_s    = (cnt_r == LAST_IDX);
    idx_nxt_s = next_idx(idx_r);
  end

  // Scheduler FSM with snapshot capture and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      idx_r        <= {ID_W{1'b0}};
      cnt_r        <= {ID_W{1'b0}};
      base_r       <= {ID_W{1'b0}};
      snap_en_r    <= {N_ACTORS{1'b0}};
      for (int i = 0; i < N_ACTORS; i++) begin
        snap_pos_r[i] <= {POS_W{1'b0}};
        snap_spr_r[i] <= {SPR_W{1'b0}};
      end
      out_valid    <= 1'b0;
      position_out <= {POS_W{1'b0}};
      sprite_out   <= {SPR_W{1'b0}};
      actor_id     <= {ID_W{1'b0}};
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            for (int i = 0; i < N_ACTORS; i++) begin
              snap_pos_r[i] <= positions[i*POS_W +: POS_W];
              snap_spr_r[i] <= sprites[i*SPR_W +: SPR_W];
            end
            snap_en_r <= enables;
            idx_r     <= base_r;
            cnt_r     <= {ID_W{1'b0}};
            busy      <= 1'b1;
            state_r   <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (sel_en_s) begin
            position_out <= sel_pos_s;
            sprite_out   <= sel_spr_s;
            actor_id     <= idx_r;
            out_valid    <= 1'b1;
            state_r      <= ST_OUT;
          end else if (last_s) begin
            busy    <= 1'b0;
            state_r <= ST_DONE;
          end else begin
            idx_r <= idx_nxt_s;
            cnt_r <= cnt_r + ID_W'(1);
          end
        end
        ST_OUT: begin
          // Data stays frozen until the renderer takes it.
          if (out_ready) begin
            out_valid <= 1'b0;
            if (last_s) begin
              busy    <= 1'b0;
              state_r <= ST_DONE;
            end else begin
              idx_r   <= idx_nxt_s;
              cnt_r   <= cnt_r + ID_W'(1);
              state_r <= ST_SCAN;
            end
          end
        end
        ST_DONE: begin
          // start is deliberately not looked at here.
          done    <= 1'b1;
          state_r <= ST_IDLE;
          if (ROTATE != 0) begin
            base_r <= next_idx(base_r);
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule
